// File: rtl/multiply_unit.sv
// +--------------------------------------------------------------------------+
// | multiply_unit : iterative radix-2 shift-add multiplier (MUL/MLA, xMULL/xMLAL)
// | Optional macro MULTIPLY_UNIT_EARLY_TERM_EN stops RUN after top bit of |b|.
// | Revision: 1.0
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module multiply_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 flush,
  input  logic                 long_mul,
  input  logic                 is_signed,
  input  logic                 accumulate,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2*WIDTH-1:0]   acc,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 flag_n,
  output logic                 flag_z
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_prod;
  logic [2*WIDTH-1:0]   r_acc;
  logic                 r_long;
  logic                 r_neg;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_flag_n;
  logic                 r_flag_z;

  logic                 w_accept;
  logic                 w_last;
  logic                 w_sgn_op;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [2*WIDTH-1:0]   w_prod_next;
  logic [2*WIDTH-1:0]   w_sgn_prod;
  logic [2*WIDTH-1:0]   w_sum;
  logic [2*WIDTH-1:0]   w_res;
  logic                 w_res_n;
  logic                 w_res_z;

  assign w_accept = (r_state == S_IDLE) && start && !flush;
  assign w_sgn_op = long_mul && is_signed;
  assign w_abs_a  = (w_sgn_op && a[WIDTH-1]) ? -a : a;
  assign w_abs_b  = (w_sgn_op && b[WIDTH-1]) ? -b : b;

`ifdef MULTIPLY_UNIT_EARLY_TERM_EN
  // Last iteration once no set multiplier bits remain above the current one.
  assign w_last = (r_mplier[WIDTH-1:1] == '0);
`else
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  logic [CNT_W-1:0] r_cnt;
  assign w_last = (r_cnt == CNT_LAST);
`endif

  assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_sgn_prod  = r_neg ? -w_prod_next : w_prod_next;
  assign w_sum       = w_sgn_prod + r_acc;
  assign w_res       = r_long ? w_sum : {{WIDTH{1'b0}}, w_sum[WIDTH-1:0]};
  assign w_res_n     = r_long ? w_sum[2*WIDTH-1] : w_sum[WIDTH-1];
  assign w_res_z     = r_long ? (w_sum == '0) : (w_sum[WIDTH-1:0] == '0);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
      S_RUN: begin
        if (flush)       w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN:   busy = 1'b1;
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_acc    <= '0;
      r_long   <= 1'b0;
      r_neg    <= 1'b0;
      r_result <= '0;
      r_flag_n <= 1'b0;
      r_flag_z <= 1'b0;
`ifndef MULTIPLY_UNIT_EARLY_TERM_EN
      r_cnt    <= '0;
`endif
    end else if (w_accept) begin
      r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
      r_mplier <= w_abs_b;
      r_prod   <= '0;
      r_acc    <= accumulate ? acc : '0;
      r_long   <= long_mul;
      r_neg    <= w_sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifndef MULTIPLY_UNIT_EARLY_TERM_EN
      r_cnt    <= '0;
`endif
    end else if ((r_state == S_RUN) && !flush) begin
      r_prod   <= w_prod_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
`ifndef MULTIPLY_UNIT_EARLY_TERM_EN
      r_cnt    <= r_cnt + CNT_W'(1);
`endif
      // Result and flags only change on the RUN -> DONE transition.
      if (w_last) begin
        r_result <= w_res;
        r_flag_n <= w_res_n;
        r_flag_z <= w_res_z;
      end
    end
  end

  assign result = r_result;
  assign flag_n = r_flag_n;
  assign flag_z = r_flag_z;

endmodule

`default_nettype wire

// File: tb/tb_multiply_unit.sv
// +--------------------------------------------------------------------------+
// | tb_multiply_unit : table-driven self-checking bench with result scoreboard
// | Revision: 1.0
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_multiply_unit;

  localparam int WIDTH = 32;

  typedef struct {
    logic        lm;
    logic        sg;
    logic        ac;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] acc;
    logic [63:0] er;
    logic        en;
    logic        ez;
  } vec_t;

  typedef struct {
    logic [63:0] r;
    logic        n;
    logic        z;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, flush, long_mul, is_signed, accumulate;
  logic [31:0] a, b;
  logic [63:0] acc;
  logic        busy, done, flag_n, flag_z;
  logic [63:0] result;

  int          checks = 0;
  int          failures = 0;
  int          seq_done_cnt;
  exp_t        sb_q[$];
  logic [63:0] last_res = '0;
  logic        last_n = 1'b0;
  logic        last_z = 1'b0;
  vec_t        vt[14];

  multiply_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .flush(flush),
    .long_mul(long_mul), .is_signed(is_signed), .accumulate(accumulate),
    .a(a), .b(b), .acc(acc), .busy(busy), .done(done), .result(result),
    .flag_n(flag_n), .flag_z(flag_z)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic lm, input logic sg, input logic ac,
                                        input logic [31:0] ma, input logic [31:0] mb,
                                        input logic [63:0] macc);
    logic signed [63:0] sa, sb;
    logic [63:0] p;
    logic [31:0] s;
    if (lm) begin
      if (sg) begin
        sa = {{32{ma[31]}}, ma};
        sb = {{32{mb[31]}}, mb};
        p  = sa * sb;
      end else begin
        p = {32'b0, ma} * {32'b0, mb};
      end
      if (ac) p = p + macc;
    end else begin
      s = ma * mb;
      if (ac) s = s + macc[31:0];
      p = {32'b0, s};
    end
    return p;
  endfunction

  function automatic int lat_of(input logic lm, input logic sg, input logic [31:0] mb);
    logic [31:0] m;
    int iters;
    m = (lm && sg && mb[31]) ? -mb : mb;
    iters = 1;
    for (int i = 0; i < 32; i++) if (m[i]) iters = i + 1;
`ifdef MULTIPLY_UNIT_EARLY_TERM_EN
    return iters + 1;
`else
    return (iters > 0) ? WIDTH + 1 : WIDTH + 1;
`endif
  endfunction

  task automatic apply_inputs(input vec_t v);
    exp_t e;
    long_mul = v.lm; is_signed = v.sg; accumulate = v.ac;
    a = v.a; b = v.b; acc = v.acc;
    start = 1'b1;
    e.r = v.er; e.n = v.en; e.z = v.ez;
    e.lat = lat_of(v.lm, v.sg, v.b);
    sb_q.push_back(e);
  endtask

  task automatic scramble();
    a = $urandom; b = $urandom; acc = {$urandom, $urandom};
    long_mul = 1'($urandom_range(0, 1));
    is_signed = 1'($urandom_range(0, 1));
    accumulate = 1'($urandom_range(0, 1));
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (done) seq_done_cnt++;
  endtask

  // Called one time unit into cycle 1 (the cycle after the accepting edge).
  task automatic wait_done(input string name);
    exp_t e;
    bit seen, busy_ok;
    int lat_seen;
    seen = 0; busy_ok = 1; lat_seen = 0;
    for (int k = 1; k <= WIDTH + 8 && !seen; k++) begin
      if (!busy) busy_ok = 0;
      if (done) begin
        seen = 1;
        lat_seen = k;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk({name, "_done_seen"}, 64'(seen), 64'd1);
    chk({name, "_busy"}, 64'(busy_ok), 64'd1);
    if (seen) begin
      chk({name, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk({name, "_latency"}, 64'(lat_seen), 64'(e.lat));
        chk({name, "_result"}, result, e.r);
        chk({name, "_flags"}, {62'b0, flag_n, flag_z}, {62'b0, e.n, e.z});
        last_res = e.r; last_n = e.n; last_z = e.z;
      end
      @(posedge clk); #1;
      chk({name, "_idle_after"}, {62'b0, busy, done}, 64'd0);
    end
  endtask

  task automatic run_op(input vec_t v, input string name);
    @(negedge clk);
    apply_inputs(v);
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    wait_done(name);
  endtask

  initial begin
    vec_t v;
    exp_t dropped;
    vt[0]  = '{1'b0, 1'b0, 1'b0, 32'd7,         32'd6,         64'd0,                  64'h2A,                  1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2,         64'd0,                  64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1,                  64'hFFFF_FFFE_0000_0002, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 32'd0,         32'd5,         64'd0,                  64'd0,                   1'b0, 1'b1};
    vt[4]  = '{1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 64'd0,                  64'h4000_0000_0000_0000, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'd1,         64'd0,                  64'hFFFF_FFFF_8000_0000, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'd2,         64'd0,                  64'h0000_0001_0000_0000, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hDEAD_BEEF_FFFF_FFFF, 64'd0,                   1'b0, 1'b1};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 32'h0001_0000, 32'h0000_8000, 64'd0,                  64'h0000_0000_8000_0000, 1'b1, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1,         64'd1,                  64'd0,                   1'b0, 1'b1};
    vt[10] = '{1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'd0,         64'd0,                  64'd0,                   1'b0, 1'b1};
    vt[11] = '{1'b0, 1'b0, 1'b0, 32'd3,         32'h80,        64'd0,                  64'h180,                 1'b0, 1'b0};
    vt[12] = '{1'b1, 1'b1, 1'b0, 32'd5,         32'hFFFF_FFFD, 64'd0,                  64'hFFFF_FFFF_FFFF_FFF1, 1'b1, 1'b0};
    vt[13] = '{1'b1, 1'b0, 1'b0, 32'd3,         32'd4,         64'hFF,                 64'hC,                   1'b0, 1'b0};

    reset_n = 1'b0; start = 1'b0; flush = 1'b0;
    long_mul = 1'b0; is_signed = 1'b0; accumulate = 1'b0;
    a = '0; b = '0; acc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl", {60'b0, busy, done, flag_n, flag_z}, 64'd0);
    chk("reset_result", result, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) run_op(vt[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 10; i++) begin
      v.lm = 1'($urandom_range(0, 1)); v.sg = 1'($urandom_range(0, 1));
      v.ac = 1'($urandom_range(0, 1));
      v.a = $urandom; v.b = (i < 3) ? ($urandom >> (8 * i + 4)) : $urandom;
      v.acc = {$urandom, $urandom};
      v.er = model(v.lm, v.sg, v.ac, v.a, v.b, v.acc);
      v.en = v.lm ? v.er[63] : v.er[31];
      v.ez = v.lm ? (v.er == 64'd0) : (v.er[31:0] == 32'd0);
      run_op(v, $sformatf("rnd%0d", i));
    end

    // Flush in RUN with a re-asserted start along the way.
    seq_done_cnt = 0;
    @(negedge clk);
    apply_inputs(vt[4]);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) step();
    start = 1'b1; a = 32'd9; b = 32'd9;
    step();
    start = 1'b0;
    repeat (4) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_no_done", 64'(seq_done_cnt), 64'd0);
    chk("flush_result_held", result, last_res);
    chk("flush_flags_held", {62'b0, flag_n, flag_z}, {62'b0, last_n, last_z});
    dropped = sb_q.pop_front();
    repeat (40) step();
    chk("flush_no_queued_start", 64'(seq_done_cnt), 64'd0);
    run_op(vt[0], "after_flush");

    // Flush wins over start in IDLE.
    @(negedge clk);
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start_idle", {62'b0, busy, done}, 64'd0);

    // Asynchronous reset in the middle of an operation.
    seq_done_cnt = 0;
    @(negedge clk);
    apply_inputs(vt[1]);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_ctl", {60'b0, busy, done, flag_n, flag_z}, 64'd0);
    chk("async_reset_result", result, 64'd0);
    dropped = sb_q.pop_front();
    repeat (2) @(negedge clk);
    apply_inputs(vt[2]);
    reset_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    chk("reset_no_done", 64'(seq_done_cnt), 64'd0);
    wait_done("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multiply_unit.md
MULTIPLY_UNIT -- requirements
Module: multiply_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; result width is 2*WIDTH.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request from the decoder's mult control, already condition-qualified.
REQ-005 SHALL have port flush  input  1  synchronous pipeline cancel.
REQ-006 SHALL have port long_mul  input  1  1 selects the 64-bit (UMULL/SMULL family), 0 selects the 32-bit (MUL/MLA) form.
REQ-007 SHALL have port is_signed  input  1  signed operands; long form only.
REQ-008 SHALL have port accumulate  input  1  add acc to the product.
REQ-009 SHALL have port a  input  WIDTH  multiplicand (Rm).
REQ-010 SHALL have port b  input  WIDTH  multiplier (Rs).
REQ-011 SHALL have port acc  input  2*WIDTH  accumulator: {RdHi,RdLo}, or {0,Rn} for the short form.
REQ-012 SHALL have port busy  output  1  operation in progress.
REQ-013 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-014 SHALL have port result  output  2*WIDTH  registered product.
REQ-015 SHALL have port flag_n, flag_z  output  1 each  negative and zero flags of the result.

Function
REQ-016 SHALL implement the states IDLE, RUN and DONE.
REQ-017 SHALL accept start only in IDLE, capturing a, b, acc and the mode bits; later input changes SHALL have no effect on the operation.
REQ-018 SHALL ignore start while in RUN or DONE, with no queuing.
REQ-019 SHALL execute a radix-2 shift-add of |a| by |b|, one multiplier bit per RUN cycle; fixed mode takes WIDTH RUN cycles.
REQ-020 SHALL, for an accept at cycle 0, assert busy in cycles 1..WIDTH+1 and pulse done in cycle WIDTH+1, with DONE lasting exactly one cycle before the return to IDLE.
REQ-021 SHALL, in signed long form, negate the magnitude product when a[MSB] XOR b[MSB] is 1, before accumulation.
REQ-022 SHALL compute the long-form result as (product + acc) mod 2^(2*WIDTH).
REQ-023 SHALL compute the short-form result as {0, (a*b + acc[WIDTH-1:0]) mod 2^WIDTH}, ignoring is_signed.
REQ-024 SHALL take flag_n from result[2*WIDTH-1] in long form and result[WIDTH-1] in short form.
REQ-025 SHALL set flag_z when the active result width is all zero.
REQ-026 SHALL update result, flag_n and flag_z only on entry to DONE, holding them until the next completed operation.
REQ-027 SHALL, when flush is high in RUN or DONE, go to IDLE next cycle with busy=0, suppress done if not yet pulsed, and leave result unchanged.
REQ-028 SHALL give flush priority when start and flush are high together in IDLE: the start is not accepted.
REQ-029 SHALL produce a correct result for operands of 0 and for 0x8000_0000 in signed mode (magnitude 2^31, no overflow).

Reset
REQ-030 SHALL, on reset_n low, immediately force state=IDLE, busy=0, done=0, result=0, flag_n=0 and flag_z=0, including mid-operation.
REQ-031 SHALL treat the first rising clk edge after reset_n rises as able to accept start.

Configuration
REQ-032 SHALL, with macro MULTIPLY_UNIT_EARLY_TERM_EN defined, run RUN for max(1, index of the highest set bit of |b| + 1) cycles, so done appears at cycle iterations+1.
REQ-033 SHALL, without MULTIPLY_UNIT_EARLY_TERM_EN, use the fixed WIDTH-cycle RUN, with results identical in both builds.

Verification
REQ-034 SHALL pass: short form, a=7, b=6, acc=0 -> done at cycle 33, result=0x0000_0000_0000_002A, flag_n=0, flag_z=0.
REQ-035 SHALL pass: SMULL, a=0xFFFF_FFFF, b=2 -> result=0xFFFF_FFFF_FFFF_FFFE, flag_n=1.
REQ-036 SHALL pass: UMLAL, a=b=0xFFFF_FFFF, acc=1 -> result=0xFFFF_FFFE_0000_0002.
REQ-037 SHALL pass: start re-asserted at cycle 5, then flush at cycle 10 -> no done pulse, busy=0 at cycle 11, result still holds the previous value, next start accepted.
REQ-038 SHALL pass: reset_n low at cycle 5 of an operation -> busy, done and result are 0 without waiting for a clock edge, and no done pulse follows.
REQ-039 SHALL pass, with EARLY_TERM_EN: b=0 -> done at cycle 2; b=0x80 -> done at cycle 9; both with correct results.
